// File: rtl/writeback_unit.sv
// writeback_unit
//   Final pipeline stage. It takes one instruction at a time and produces a
//   registered register-file write. ALU-style results (sources 1..NUM_SRC-1)
//   retire one cycle after accept. Loads (source 0) retire one cycle after
//   the memory response arrives, and may stall in WAIT_MEM until it does.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               drop the offered or pending instruction
//   in_valid/in_ready   instruction handshake; ready only in IDLE
//   in_wb_en, in_rd     write enable and destination register
//   in_wb_sel           result source (0 = memory)
//   in_src_data         flattened sources, slot k = [k*XLEN +: XLEN]
//   in_ld_size/unsigned/byte_off  load formatting controls
//   mem_rsp_valid/data  memory response (raw aligned word)
//   rf_we/waddr/wdata   registered register-file write port
//   busy                high while waiting on memory
//   spurious_rsp        sticky flag for an unexpected memory response
//   wb_count            count of retired register writes (wraps)
module writeback_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int RA_W    = 5,
  localparam int SEL_W  = $clog2(NUM_SRC),
  localparam int OFF_W  = $clog2(XLEN/8)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_wb_en,
  input  logic [RA_W-1:0]         in_rd,
  input  logic [SEL_W-1:0]        in_wb_sel,
  input  logic [NUM_SRC*XLEN-1:0] in_src_data,
  input  logic [1:0]              in_ld_size,
  input  logic                    in_ld_unsigned,
  input  logic [OFF_W-1:0]        in_byte_off,
  input  logic                    mem_rsp_valid,
  input  logic [XLEN-1:0]         mem_rsp_data,
  output logic                    rf_we,
  output logic [RA_W-1:0]         rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    busy,
  output logic                    spurious_rsp,
  output logic [31:0]             wb_count
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t state, state_nxt;

  // Load fields captured when a load has to wait for its response
  logic [RA_W-1:0]  lat_rd;
  logic [1:0]       lat_size;
  logic             lat_uns;
  logic [OFF_W-1:0] lat_off;

  logic             accept, is_load, lat_load, spur_set;
  logic             we_nxt, upd_nxt;
  logic [RA_W-1:0]  waddr_nxt;
  logic [XLEN-1:0]  wdata_nxt, src_sel, ld_data;
  logic [1:0]       fmt_size;
  logic             fmt_uns;
  logic [OFF_W-1:0] fmt_off;

  // Slot 0 is the memory position and carries no data on this bus
  logic [XLEN-1:0] unused_slot0;
  assign unused_slot0 = in_src_data[XLEN-1:0];

  assign in_ready = (state == IDLE);
  assign busy     = (state == WAIT_MEM);
  assign accept   = in_valid && in_ready && !flush;
  assign is_load  = (in_wb_sel == '0) && in_wb_en;

  // Shift the response down to the addressed byte, keep the access width,
  // then sign- or zero-extend. Size 3 keeps the full word, which on a 32-bit
  // datapath is the same as size 2.
  function automatic logic [XLEN-1:0] ld_fmt(
    input logic [XLEN-1:0]  raw,
    input logic [1:0]       size,
    input logic             uns,
    input logic [OFF_W-1:0] off
  );
    logic [XLEN-1:0] sh, mask;
    logic            sb;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    begin mask = XLEN'(8'hFF);         sb = sh[7];      end
      2'd1:    begin mask = XLEN'(16'hFFFF);      sb = sh[15];     end
      2'd2:    begin mask = XLEN'(32'hFFFF_FFFF); sb = sh[31];     end
      default: begin mask = '1;                   sb = sh[XLEN-1]; end
    endcase
    if (uns || !sb) ld_fmt = sh & mask;
    else            ld_fmt = (sh & mask) | ~mask;
  endfunction

  // One formatter serves both the same-cycle and the delayed load
  assign fmt_size = in_ready ? in_ld_size     : lat_size;
  assign fmt_uns  = in_ready ? in_ld_unsigned : lat_uns;
  assign fmt_off  = in_ready ? in_byte_off    : lat_off;
  assign ld_data  = ld_fmt(mem_rsp_data, fmt_size, fmt_uns, fmt_off);

  // Out-of-range selects fall through to zero
  always_comb begin
    src_sel = '0;
    for (int k = 1; k < NUM_SRC; k++)
      if (in_wb_sel == SEL_W'(k)) src_sel = in_src_data[k*XLEN +: XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    upd_nxt   = 1'b0;
    waddr_nxt = in_rd;
    wdata_nxt = src_sel;
    lat_load  = 1'b0;
    spur_set  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_load && !mem_rsp_valid) begin
            state_nxt = WAIT_MEM;
            lat_load  = 1'b1;
          end else begin
            we_nxt    = in_wb_en && (in_rd != '0);
            wdata_nxt = is_load ? ld_data : src_sel;
          end
        end
        // A response is only expected by a load being accepted right now
        if (mem_rsp_valid && !(accept && is_load)) spur_set = 1'b1;
      end
      WAIT_MEM: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (mem_rsp_valid) begin
          state_nxt = IDLE;
          we_nxt    = (lat_rd != '0);
          waddr_nxt = lat_rd;
          wdata_nxt = ld_data;
        end
      end
      default: state_nxt = IDLE;
    endcase
    upd_nxt = we_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rd   <= '0;
      lat_size <= '0;
      lat_uns  <= 1'b0;
      lat_off  <= '0;
    end else if (lat_load) begin
      lat_rd   <= in_rd;
      lat_size <= in_ld_size;
      lat_uns  <= in_ld_unsigned;
      lat_off  <= in_byte_off;
    end
  end

  // wb_count advances on the same edge that raises rf_we, so the two are
  // always consistent when observed together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      spurious_rsp <= 1'b0;
      wb_count     <= '0;
    end else begin
      rf_we    <= we_nxt;
      wb_count <= wb_count + 32'(we_nxt);
      if (upd_nxt) begin
        rf_waddr <= waddr_nxt;
        rf_wdata <= wdata_nxt;
      end
      if (spur_set) spurious_rsp <= 1'b1;
    end
  end

endmodule
